// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with start/annul/ready handshake to the hazard unit.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     opd;
    logic [2*WIDTH-1:0]   acc;

    // Handshake: start_i is taken only in IDLE or DONE (not with annul_i in IDLE);
    // busy_o is high for every RUN cycle; ready_o pulses for the single DONE cycle,
    // and hi_o/lo_o/dbz_o stay stable from that pulse until the next accepted start.
    logic             accept;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;

    assign accept    = start_i && ((state == S_IDLE && !annul_i) || state == S_DONE);
    assign in_signed = ~op_i[0];
    assign a_neg     = in_signed & a_i[WIDTH-1];
    assign b_neg     = in_signed & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    assign div_zero  = op_i[1] && (b_i == '0);

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits then quotient bits}, shifted left each step.
    // The remainder stays below the divisor, so the difference MSB is a clean borrow flag.
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;

    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opd};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign step_next = is_div ? div_next : mul_next;
    assign prod_fix  = (sign_a ^ sign_b) ? -mul_next : mul_next;
    assign quo_fix   = (sign_a ^ sign_b) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem_fix   = sign_a ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    assign res_hi    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo    = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            opd     <= '0;
            acc     <= '0;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            dbz_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        is_div <= op_i[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        cnt    <= '0;
                        dbz_o  <= 1'b0;
                        if (div_zero) begin
                            // Divide by zero bypasses RUN and reports immediately.
                            state   <= S_DONE;
                            busy_o  <= 1'b0;
                            ready_o <= 1'b1;
                            hi_o    <= a_i;
                            lo_o    <= '1;
                            dbz_o   <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            busy_o <= 1'b1;
                            acc    <= {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
                            opd    <= op_i[1] ? b_mag : a_mag;
                        end
                    end else begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (annul_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt == LAST) begin
                        state   <= S_DONE;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                        acc     <= step_next;
                        hi_o    <= res_hi;
                        lo_o    <= res_lo;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
